// File: rtl/wall_pkg.sv
// Shared types and constants for the wall map: cell encoding, sweep FSM states,
// default grid size and the power-on map.
package wall_pkg;

  typedef enum logic [1:0] {
    CellEmpty = 2'd0,
    CellBrick = 2'd1,
    CellSteel = 2'd2
  } cell_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CENTER = 3'd1,
    S_LEFT   = 3'd2,
    S_RIGHT  = 3'd3,
    S_UP     = 3'd4,
    S_DOWN   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam int unsigned DEF_GRID_COLS = 20;
  localparam int unsigned DEF_GRID_ROWS = 15;
  localparam int unsigned BLOCK_SHIFT   = 5;

  // Power-on map: steel border ring and pillars at even/even cells, a small
  // empty pocket in the top-left corner as the spawn area, brick elsewhere.
  function automatic cell_t init_cell(input int unsigned col, input int unsigned row,
                                      input int unsigned cols, input int unsigned rows);
    if (col == 0 || row == 0 || col == cols - 1 || row == rows - 1) return CellSteel;
    if ((col % 2 == 0) && (row % 2 == 0)) return CellSteel;
    if ((col == 1 && row == 1) || (col == 2 && row == 1) || (col == 1 && row == 2)) begin
      return CellEmpty;
    end
    return CellBrick;
  endfunction

endpackage

// File: rtl/wall_pixel_lookup.sv
// Combinational pixel-to-cell lookup: reports whether the current drawing pixel
// falls in a brick or a steel cell of the live map.
module wall_pixel_lookup
  import wall_pkg::*;
#(
  parameter int unsigned GRID_COLS = DEF_GRID_COLS,
  parameter int unsigned GRID_ROWS = DEF_GRID_ROWS
) (
  input  logic [10:0]                          pixelX,
  input  logic [10:0]                          pixelY,
  input  cell_t [GRID_COLS*GRID_ROWS-1:0]      map,
  output logic                                 brick_DrawReq,
  output logic                                 steel_DrawReq
);

  localparam int unsigned NCells  = GRID_COLS * GRID_ROWS;
  localparam int unsigned IdxW    = (NCells > 1) ? $clog2(NCells) : 1;
  localparam logic [6:0]  ColsW   = 7'(GRID_COLS);
  localparam logic [6:0]  RowsW   = 7'(GRID_ROWS);
  localparam logic [IdxW-1:0] ColsIdx = IdxW'(GRID_COLS);

  logic [6:0]      pix_col;
  logic [6:0]      pix_row;
  logic            pix_in_range;
  logic [IdxW-1:0] pix_idx;
  cell_t           pix_cell;
  logic            unused_pixel_bits;

  assign unused_pixel_bits = ^{pixelX[BLOCK_SHIFT-1:0], pixelY[BLOCK_SHIFT-1:0]};

  // Decode the pixel's cell and classify it; out-of-grid pixels draw nothing.
  always_comb begin
    pix_col      = {1'b0, pixelX[10:BLOCK_SHIFT]};
    pix_row      = {1'b0, pixelY[10:BLOCK_SHIFT]};
    pix_in_range = (pix_col < ColsW) && (pix_row < RowsW);
    pix_idx      = IdxW'(pix_row) * ColsIdx + IdxW'(pix_col);
    pix_cell     = CellEmpty;
    if (pix_in_range) pix_cell = map[pix_idx];
    brick_DrawReq = (pix_cell == CellBrick);
    steel_DrawReq = (pix_cell == CellSteel);
  end

endmodule

// File: rtl/wall_map_ctrl.sv
// Wall map controller: holds the cell map, runs the five-cell destruction sweep
// around a bomb, counts destroyed bricks and drives the draw requests.
module wall_map_ctrl
  import wall_pkg::*;
#(
  parameter int unsigned GRID_COLS = DEF_GRID_COLS,
  parameter int unsigned GRID_ROWS = DEF_GRID_ROWS
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               enable_wall_destruct,
  input  logic signed [10:0] bombX,
  input  logic signed [10:0] bombY,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  output logic               brick_DrawReq,
  output logic               steel_DrawReq,
  output logic               busy,
  output logic               brick_destroyed,
  output logic [7:0]         bricks_count
);

  localparam int unsigned NCells  = GRID_COLS * GRID_ROWS;
  localparam int unsigned IdxW    = (NCells > 1) ? $clog2(NCells) : 1;
  localparam logic [6:0]  ColsW   = 7'(GRID_COLS);
  localparam logic [6:0]  RowsW   = 7'(GRID_ROWS);
  localparam logic [IdxW-1:0] ColsIdx = IdxW'(GRID_COLS);

  state_t          state_q, state_d;
  cell_t [NCells-1:0] map_q;
  logic [5:0]      bomb_col_q, bomb_row_q;
  logic [7:0]      count_q;

  logic [6:0]      bomb_col, bomb_row;
  logic            bomb_ok;
  logic            accept;
  logic [6:0]      tgt_col, tgt_row;
  logic            tgt_valid;
  logic [IdxW-1:0] tgt_idx;
  logic            hit;
  logic            unused_bomb_bits;

  assign unused_bomb_bits = ^{bombX[BLOCK_SHIFT-1:0], bombY[BLOCK_SHIFT-1:0]};

  // Bomb cell decode; a set sign bit means the bomb is off the top/left edge.
  always_comb begin
    bomb_col = {1'b0, bombX[10:BLOCK_SHIFT]};
    bomb_row = {1'b0, bombY[10:BLOCK_SHIFT]};
    bomb_ok  = !bombX[10] && !bombY[10] && (bomb_col < ColsW) && (bomb_row < RowsW);
    accept   = (state_q == S_IDLE) && enable_wall_destruct && bomb_ok;
  end

  // Sweep FSM next state: leave idle on an accepted request, then step through
  // the five target cells unconditionally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_CENTER;
      S_CENTER: state_d = S_LEFT;
      S_LEFT:   state_d = S_RIGHT;
      S_RIGHT:  state_d = S_UP;
      S_UP:     state_d = S_DOWN;
      S_DOWN:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Target cell of the current sweep state; edge neighbours outside the grid
  // are flagged invalid so they never touch the map.
  always_comb begin
    tgt_col   = {1'b0, bomb_col_q};
    tgt_row   = {1'b0, bomb_row_q};
    tgt_valid = 1'b0;
    case (state_q)
      S_CENTER: tgt_valid = 1'b1;
      S_LEFT: begin
        tgt_col   = {1'b0, bomb_col_q} - 7'd1;
        tgt_valid = (bomb_col_q != 6'd0);
      end
      S_RIGHT: begin
        tgt_col   = {1'b0, bomb_col_q} + 7'd1;
        tgt_valid = (tgt_col < ColsW);
      end
      S_UP: begin
        tgt_row   = {1'b0, bomb_row_q} - 7'd1;
        tgt_valid = (bomb_row_q != 6'd0);
      end
      S_DOWN: begin
        tgt_row   = {1'b0, bomb_row_q} + 7'd1;
        tgt_valid = (tgt_row < RowsW);
      end
      default: tgt_valid = 1'b0;
    endcase
    tgt_idx = IdxW'(tgt_row) * ColsIdx + IdxW'(tgt_col);
    hit     = tgt_valid && (map_q[tgt_idx] == CellBrick);
  end

  // FSM state and captured bomb cell.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      bomb_col_q <= 6'd0;
      bomb_row_q <= 6'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        bomb_col_q <= bomb_col[5:0];
        bomb_row_q <= bomb_row[5:0];
      end
    end
  end

  // Map storage: reset restores the power-on map, a hit clears its brick.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned r = 0; r < GRID_ROWS; r++) begin
        for (int unsigned c = 0; c < GRID_COLS; c++) begin
          map_q[r * GRID_COLS + c] <= init_cell(c, r, GRID_COLS, GRID_ROWS);
        end
      end
    end else if (hit) begin
      map_q[tgt_idx] <= CellEmpty;
    end
  end

  // Saturating count of destroyed bricks.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= 8'd0;
    end else if (hit && (count_q != 8'hFF)) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign brick_destroyed = hit;
  assign bricks_count    = count_q;

  wall_pixel_lookup #(
    .GRID_COLS(GRID_COLS),
    .GRID_ROWS(GRID_ROWS)
  ) u_lookup (
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .map          (map_q),
    .brick_DrawReq(brick_DrawReq),
    .steel_DrawReq(steel_DrawReq)
  );

endmodule

// File: tb/tb_wall_map_ctrl.sv
// Directed bench for wall_map_ctrl: map contents are observed through the
// draw-request outputs by pointing the pixel at each cell of interest.
module tb_wall_map_ctrl;

  logic               clk;
  logic               resetN;
  logic               enable_wall_destruct;
  logic signed [10:0] bombX;
  logic signed [10:0] bombY;
  logic [10:0]        pixelX;
  logic [10:0]        pixelY;
  logic               brick_DrawReq;
  logic               steel_DrawReq;
  logic               busy;
  logic               brick_destroyed;
  logic [7:0]         bricks_count;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] BRICK = 2'b01;
  localparam logic [1:0] STEEL = 2'b10;

  wall_map_ctrl #(
    .GRID_COLS(20),
    .GRID_ROWS(15)
  ) dut (
    .clk                 (clk),
    .resetN              (resetN),
    .enable_wall_destruct(enable_wall_destruct),
    .bombX               (bombX),
    .bombY               (bombY),
    .pixelX              (pixelX),
    .pixelY              (pixelY),
    .brick_DrawReq       (brick_DrawReq),
    .steel_DrawReq       (steel_DrawReq),
    .busy                (busy),
    .brick_destroyed     (brick_destroyed),
    .bricks_count        (bricks_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reads a cell as {steel, brick} by pointing the pixel at its middle.
  task automatic check_cell(input string tag, input int c, input int r, input logic [1:0] exp);
    pixelX = 11'(c * 32 + 16);
    pixelY = 11'(r * 32 + 16);
    #1;
    check_val(tag, {30'd0, steel_DrawReq, brick_DrawReq}, {30'd0, exp});
  endtask

  // Presents a one-cycle request; returns at the negedge after the accepting edge.
  task automatic fire(input logic [10:0] x, input logic [10:0] y);
    @(negedge clk);
    enable_wall_destruct = 1'b1;
    bombX = x;
    bombY = y;
    @(negedge clk);
    enable_wall_destruct = 1'b0;
  endtask

  // Observes ten cycles; optionally injects a second request at sample inj_at.
  task automatic run_window(input int inj_at, input logic [10:0] x2, input logic [10:0] y2,
                            output int pulses, output int busy_n, output int first_low);
    pulses    = 0;
    busy_n    = 0;
    first_low = -1;
    for (int i = 0; i < 10; i++) begin
      if (brick_destroyed) pulses++;
      if (busy) busy_n++;
      else if (first_low < 0) first_low = i;
      if (i == inj_at) begin
        enable_wall_destruct = 1'b1;
        bombX = x2;
        bombY = y2;
      end else begin
        enable_wall_destruct = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  int pulses, busy_n, first_low;

  initial begin
    resetN = 1'b0;
    enable_wall_destruct = 1'b0;
    bombX = '0;
    bombY = '0;
    pixelX = '0;
    pixelY = '0;
    #12;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_pulse", {31'd0, brick_destroyed}, 32'd0);
    check_val("rst_count", {24'd0, bricks_count}, 32'd0);
    check_cell("rst_c00", 0, 0, STEEL);
    check_cell("rst_c11", 1, 1, EMPTY);
    check_cell("rst_c31", 3, 1, BRICK);
    check_cell("rst_c22", 2, 2, STEEL);
    @(negedge clk);
    resetN = 1'b1;

    // Bomb at (3,1): center, right and down are bricks; left empty, up steel.
    fire(11'd96, 11'd32);
    run_window(-1, 11'd0, 11'd0, pulses, busy_n, first_low);
    check_val("t1_pulses", pulses, 3);
    check_val("t1_busy", busy_n, 6);
    check_val("t1_count", {24'd0, bricks_count}, 3);
    check_cell("t1_c31", 3, 1, EMPTY);
    check_cell("t1_c41", 4, 1, EMPTY);
    check_cell("t1_c21", 2, 1, EMPTY);
    check_cell("t1_c30", 3, 0, STEEL);
    check_cell("t1_c32", 3, 2, EMPTY);

    // Bomb at (1,3): left is the border steel, up is the empty pocket.
    fire(11'd32, 11'd96);
    run_window(-1, 11'd0, 11'd0, pulses, busy_n, first_low);
    check_val("t2_pulses", pulses, 3);
    check_val("t2_count", {24'd0, bricks_count}, 6);
    check_cell("t2_c03", 0, 3, STEEL);
    check_cell("t2_c12", 1, 2, EMPTY);
    check_cell("t2_c14", 1, 4, EMPTY);
    check_cell("t2_c23", 2, 3, EMPTY);
    check_cell("t2_c13", 1, 3, EMPTY);

    // Bomb at (5,5) with a second request for (10,10) two cycles later.
    fire(11'd160, 11'd160);
    run_window(1, 11'd320, 11'd320, pulses, busy_n, first_low);
    check_val("t3_pulses", pulses, 5);
    check_val("t3_busy", busy_n, 6);
    check_val("t3_low_at", first_low, 6);
    check_val("t3_count", {24'd0, bricks_count}, 11);
    check_cell("t3_c55", 5, 5, EMPTY);
    check_cell("t3_c56", 5, 6, EMPTY);
    check_cell("t3_c9_10", 9, 10, BRICK);
    check_cell("t3_c10_9", 10, 9, BRICK);

    // Out-of-range bombs are ignored.
    fire(11'h7E0, 11'd32);
    run_window(-1, 11'd0, 11'd0, pulses, busy_n, first_low);
    check_val("t4n_busy", busy_n, 0);
    check_val("t4n_pulses", pulses, 0);
    check_cell("t4n_c01", 0, 1, STEEL);
    check_cell("t4n_c71", 7, 1, BRICK);
    fire(11'd640, 11'd32);
    run_window(-1, 11'd0, 11'd0, pulses, busy_n, first_low);
    check_val("t4p_busy", busy_n, 0);
    check_val("t4p_pulses", pulses, 0);
    check_cell("t4p_c18_1", 18, 1, BRICK);
    check_val("t4_count", {24'd0, bricks_count}, 11);

    // Bomb on the last column: right neighbour is off-grid.
    fire(11'd608, 11'd32);
    run_window(-1, 11'd0, 11'd0, pulses, busy_n, first_low);
    check_val("t5_pulses", pulses, 1);
    check_val("t5_busy", busy_n, 6);
    check_val("t5_count", {24'd0, bricks_count}, 12);
    check_cell("t5_c18_1", 18, 1, EMPTY);
    check_cell("t5_c19_1", 19, 1, STEEL);

    // Reset during S_RIGHT of a sweep at (7,3).
    fire(11'd224, 11'd96);
    @(negedge clk);
    check_cell("t6_c73_clr", 7, 3, EMPTY);
    @(negedge clk);
    check_val("t6_busy_pre", {31'd0, busy}, 1);
    resetN = 1'b0;
    #1;
    check_val("t6_busy", {31'd0, busy}, 0);
    check_val("t6_count", {24'd0, bricks_count}, 0);
    check_val("t6_pulse", {31'd0, brick_destroyed}, 0);
    check_cell("t6_c73", 7, 3, BRICK);
    check_cell("t6_c31", 3, 1, BRICK);
    check_cell("t6_c55", 5, 5, BRICK);
    @(negedge clk);
    resetN = 1'b1;

    // Draw path: cleared cell stops drawing the cycle after its pulse.
    pixelX = 11'd100;
    pixelY = 11'd40;
    fire(11'd96, 11'd32);
    check_val("t7_pulse0", {31'd0, brick_destroyed}, 1);
    check_val("t7_draw0", {31'd0, brick_DrawReq}, 1);
    @(negedge clk);
    check_val("t7_draw1", {31'd0, brick_DrawReq}, 0);
    repeat (8) @(negedge clk);
    check_val("t7_count", {24'd0, bricks_count}, 3);
    pixelX = 11'd100;
    pixelY = 11'd40;
    #1;
    check_val("t7_brick_100_40", {31'd0, brick_DrawReq}, 0);
    pixelX = 11'd5;
    pixelY = 11'd5;
    #1;
    check_val("t7_steel_5_5", {31'd0, steel_DrawReq}, 1);
    check_val("t7_brick_5_5", {31'd0, brick_DrawReq}, 0);
    pixelX = 11'd700;
    pixelY = 11'd10;
    #1;
    check_val("t7_brick_700", {31'd0, brick_DrawReq}, 0);
    check_val("t7_steel_700", {31'd0, steel_DrawReq}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
